// File: rtl/button_event_ctrl.sv
// Front-panel button conditioner: synchronise, debounce, priority-encode and emit press events over valid/ready.
// Optional auto-repeat of the held button is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_ctrl #(
    parameter  int N_BTN           = 3,
    parameter  int DEBOUNCE_CYCLES = 500000,
    parameter  int REPEAT_DELAY    = 25000000,
    parameter  int REPEAT_PERIOD   = 5000000,
    localparam int CODE_W          = $clog2(N_BTN + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_BTN-1:0]  i_btn_in,
    output logic [N_BTN-1:0]  o_btn_db,
    output logic [CODE_W-1:0] o_held_code,
    output logic              o_evt_valid,
    output logic [CODE_W-1:0] o_evt_code,
    input  logic              i_evt_ready,
    output logic              o_evt_overflow,
    input  logic              i_ovf_clr
);

    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (N_BTN < 1 || N_BTN > 15 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("button_event_ctrl: parameter out of range");
    end

    function automatic logic [CODE_W-1:0] lowest_code(input logic [N_BTN-1:0] v);
        lowest_code = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) lowest_code = CODE_W'(i + 1);
        end
    endfunction

    logic [N_BTN-1:0]  r_sync1;
    logic [N_BTN-1:0]  r_sync2;
    logic [N_BTN-1:0]  r_btn_db;
    logic [N_BTN-1:0]  r_btn_db_q;
    logic [DB_W-1:0]   r_db_cnt [N_BTN];
    logic [CODE_W-1:0] r_held_code;
    logic              r_evt_valid;
    logic [CODE_W-1:0] r_evt_code;
    logic              r_evt_overflow;

    logic [N_BTN-1:0]  w_rise;
    logic              w_edge_any;
    logic              w_edge_multi;
    logic [CODE_W-1:0] w_edge_code;
    logic [CODE_W-1:0] w_held_next;
    logic              w_src_valid;
    logic [CODE_W-1:0] w_src_code;
    logic              w_can_load;
    logic              w_drop;

    // A level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_btn_db   <= '0;
            r_btn_db_q <= '0;
            for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1    <= i_btn_in;
            r_sync2    <= r_sync1;
            r_btn_db_q <= r_btn_db;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_btn_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_btn_db[i] <= ~r_btn_db[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign w_rise       = r_btn_db & ~r_btn_db_q;
    assign w_edge_any   = |w_rise;
    assign w_edge_multi = |(w_rise & (w_rise - N_BTN'(1)));
    assign w_edge_code  = lowest_code(w_rise);
    assign w_held_next  = lowest_code(r_btn_db);

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TIMER_W = $clog2(REP_MAX + 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    rep_state_t         r_rep_state;
    rep_state_t         w_rep_next;
    logic [TIMER_W-1:0] r_rep_timer;
    logic               w_held_change;
    logic               w_rep_fire;

    // The FSM follows the held code about to be registered, so it moves in lockstep with o_held_code.
    assign w_held_change = (w_held_next != r_held_code);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rep_state <= IDLE;
            r_rep_timer <= '0;
        end else begin
            r_rep_state <= w_rep_next;
            if (w_held_change || w_rep_fire || r_rep_state == IDLE) begin
                r_rep_timer <= '0;
            end else begin
                r_rep_timer <= r_rep_timer + TIMER_W'(1);
            end
        end
    end

    always_comb begin
        w_rep_next = r_rep_state;
        if (w_held_change) begin
            w_rep_next = (w_held_next != '0) ? DELAY : IDLE;
        end else if (r_rep_state == DELAY && r_rep_timer == DELAY_LAST) begin
            w_rep_next = REPEAT;
        end
    end

    always_comb begin
        w_rep_fire = 1'b0;
        if (!w_held_change) begin
            case (r_rep_state)
                DELAY:   w_rep_fire = (r_rep_timer == DELAY_LAST);
                REPEAT:  w_rep_fire = (r_rep_timer == PERIOD_LAST);
                default: w_rep_fire = 1'b0;
            endcase
        end
    end

    // An edge event in the same cycle takes precedence; the repeat is discarded without flagging overflow.
    assign w_src_valid = w_edge_any | w_rep_fire;
    assign w_src_code  = w_edge_any ? w_edge_code : r_held_code;
`else
    assign w_src_valid = w_edge_any;
    assign w_src_code  = w_edge_code;
`endif

    assign w_can_load = ~r_evt_valid | i_evt_ready;
    assign w_drop     = w_edge_multi | (w_src_valid & ~w_can_load);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held_code    <= '0;
            r_evt_valid    <= 1'b0;
            r_evt_code     <= '0;
            r_evt_overflow <= 1'b0;
        end else begin
            r_held_code <= w_held_next;
            if (w_can_load) begin
                r_evt_valid <= w_src_valid;
                if (w_src_valid) r_evt_code <= w_src_code;
            end
            if (w_drop) begin
                r_evt_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_evt_overflow <= 1'b0;
            end
        end
    end

    assign o_btn_db       = r_btn_db;
    assign o_held_code    = r_held_code;
    assign o_evt_valid    = r_evt_valid;
    assign o_evt_code     = r_evt_code;
    assign o_evt_overflow = r_evt_overflow;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl (N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3).
// Expected repeat events depend on whether BTN_AUTOREPEAT_EN is defined for the build.
module tb_button_event_ctrl;

    logic       clk;
    logic       rstN;
    logic [2:0] btnIn;
    logic [2:0] btnDb;
    logic [1:0] heldCode;
    logic       evtValid;
    logic [1:0] evtCode;
    logic       evtReady;
    logic       evtOverflow;
    logic       ovfClr;

    int nChecks;
    int nPass;

    button_event_ctrl #(
        .N_BTN           (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_btn_in       (btnIn),
        .o_btn_db       (btnDb),
        .o_held_code    (heldCode),
        .o_evt_valid    (evtValid),
        .o_evt_code     (evtCode),
        .i_evt_ready    (evtReady),
        .o_evt_overflow (evtOverflow),
        .i_ovf_clr      (ovfClr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] btn, input logic ready, input logic clr);
        btnIn    = btn;
        evtReady = ready;
        ovfClr   = clr;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) begin
            nPass++;
        end else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic expValid;
        nChecks = 0;
        nPass   = 0;
        rstN    = 1'b0;
        applyStimulus(3'b000, 1'b1, 1'b0);
        repeat (3) tick();
        rstN = 1'b1;
        repeat (2) tick();

        $display("[TB] reset during activity");
        applyStimulus(3'b001, 1'b1, 1'b0);
        repeat (7) tick();
        checkOutput("pre_reset_valid", evtValid, 1);
        checkOutput("pre_reset_held", heldCode, 1);
        rstN = 1'b0;
        applyStimulus(3'b000, 1'b1, 1'b0);
        #1;
        checkOutput("reset_btn_db", btnDb, 0);
        checkOutput("reset_held", heldCode, 0);
        checkOutput("reset_valid", evtValid, 0);
        checkOutput("reset_code", evtCode, 0);
        checkOutput("reset_ovf", evtOverflow, 0);
        repeat (2) tick();
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("post_reset_valid_%0d", i), evtValid, 0);
        end

        $display("[TB] clean press of button 1");
        applyStimulus(3'b010, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("press_db_edge4", btnDb, 3'b000);
        tick();
        checkOutput("press_db_edge5", btnDb, 3'b010);
        checkOutput("press_valid_edge5", evtValid, 0);
        tick();
        checkOutput("press_valid_edge6", evtValid, 1);
        checkOutput("press_code_edge6", evtCode, 2);
        checkOutput("press_held_edge6", heldCode, 2);
        tick();
        checkOutput("press_valid_edge7", evtValid, 0);
        checkOutput("press_held_edge7", heldCode, 2);
        applyStimulus(3'b000, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("release_db_still_high", btnDb, 3'b010);
        tick();
        checkOutput("release_db_low", btnDb, 3'b000);
        checkOutput("release_held_lag", heldCode, 2);
        tick();
        checkOutput("release_held_zero", heldCode, 0);
        checkOutput("release_no_event", evtValid, 0);
        repeat (4) tick();

        $display("[TB] bounce on button 0");
        applyStimulus(3'b001, 1'b1, 1'b0);
        repeat (3) tick();
        applyStimulus(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput($sformatf("bounce_db_%0d", i), btnDb, 3'b000);
        end
        checkOutput("bounce_no_event", evtValid, 0);

        $display("[TB] simultaneous press");
        applyStimulus(3'b101, 1'b1, 1'b0);
        repeat (7) tick();
        checkOutput("simul_valid", evtValid, 1);
        checkOutput("simul_code", evtCode, 1);
        checkOutput("simul_ovf", evtOverflow, 1);
        checkOutput("simul_held", heldCode, 1);
        applyStimulus(3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("simul_valid_after", evtValid, 0);
        checkOutput("simul_ovf_sticky", evtOverflow, 1);
        applyStimulus(3'b000, 1'b1, 1'b1);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("simul_ovf_cleared", evtOverflow, 0);
        repeat (8) tick();
        checkOutput("simul_settled_db", btnDb, 3'b000);
        checkOutput("simul_settled_held", heldCode, 0);
        checkOutput("simul_no_fall_event", evtValid, 0);

        $display("[TB] backpressure");
        applyStimulus(3'b100, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("bp_valid", evtValid, 1);
        checkOutput("bp_code", evtCode, 3);
        checkOutput("bp_ovf_clear", evtOverflow, 0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        repeat (2) tick();
        applyStimulus(3'b001, 1'b0, 1'b0);
        repeat (7) tick();
        checkOutput("bp_valid_kept", evtValid, 1);
        checkOutput("bp_code_kept", evtCode, 3);
        checkOutput("bp_ovf_set", evtOverflow, 1);
        checkOutput("bp_held", heldCode, 1);
        applyStimulus(3'b001, 1'b1, 1'b0);
        tick();
        checkOutput("bp_accepted", evtValid, 0);
        checkOutput("bp_ovf_sticky", evtOverflow, 1);
        applyStimulus(3'b000, 1'b1, 1'b0);
        repeat (8) tick();
        checkOutput("bp_settled_held", heldCode, 0);
        applyStimulus(3'b000, 1'b1, 1'b1);
        tick();
        applyStimulus(3'b000, 1'b1, 1'b0);
        checkOutput("bp_ovf_cleared", evtOverflow, 0);
        repeat (2) tick();

        $display("[TB] hold button 0 for auto-repeat window");
        applyStimulus(3'b001, 1'b1, 1'b0);
        for (int t = 1; t <= 35; t++) begin
            tick();
            expValid = (t - 1 == 6);
`ifdef BTN_AUTOREPEAT_EN
            expValid = expValid || (t - 1 == 16) || (t - 1 == 19) || (t - 1 == 22);
`endif
            checkOutput($sformatf("hold_valid_edge%0d", t - 1), evtValid, expValid);
            if (expValid) checkOutput($sformatf("hold_code_edge%0d", t - 1), evtCode, 1);
            if (t == 19) applyStimulus(3'b000, 1'b1, 1'b0);
        end
        checkOutput("hold_ovf", evtOverflow, 0);
        checkOutput("hold_released_held", heldCode, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
# button_event_ctrl

Parametrised front-panel input conditioner that replaces the combinational button-to-state mapping feeding the game FSM. Synchronises and debounces N raw push-buttons, priority-encodes the held buttons, and delivers one press event per debounced rising edge over a valid/ready handshake, with a sticky overflow flag. Sits between the board pins and the game FSM / VGA top level.

## Interface
- N_BTN, 3, number of buttons (1–15)
- DEBOUNCE_CYCLES, 500000, stable cycles required before a debounced level changes (≥2; 10 ms at 50 MHz)
- REPEAT_DELAY, 25000000, hold cycles before the first auto-repeat event (used only with auto-repeat)
- REPEAT_PERIOD, 5000000, cycles between later auto-repeat events (used only with auto-repeat)
- CODE_W, derived as $clog2(N_BTN+1), not overridden
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_in  in  N_BTN  raw asynchronous buttons, active-high
- btn_db  out  N_BTN  debounced button levels
- held_code  out  CODE_W  index+1 of lowest-index debounced-held button; 0 = none
- evt_valid  out  1  press event pending
- evt_code  out  CODE_W  index+1 of the pressed button; stable while evt_valid
- evt_ready  in  1  consumer accepts the event
- evt_overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears evt_overflow

## Operation
- Per button: 2-flop synchroniser (sync1, sync2), then debounce counter of width $clog2(DEBOUNCE_CYCLES).
- Debounce: each cycle sync2 ≠ btn_db, counter increments; at DEBOUNCE_CYCLES-1 with mismatch still present, btn_db flips and counter clears. Any cycle with sync2 == btn_db clears the counter.
- Edge detect: rise[i] = btn_db[i] & ~btn_db_q[i], where btn_db_q is btn_db delayed one cycle. Falling edges produce no events.
- Event source: lowest set index of rise wins. Other simultaneous rises are dropped and set evt_overflow.
- Event register:
  - Empty, or accepted this cycle (evt_valid & evt_ready), and a source event is present: load evt_code; evt_valid = 1.
  - Accepted with no new event: evt_valid = 0.
  - evt_valid = 1, not accepted, and a new event arrives: new event dropped, old one kept, evt_overflow = 1.
- held_code: registered priority encode of btn_db; lowest index wins.
- evt_overflow: sets on any drop; clears on ovf_clr. Set wins when both happen in the same cycle.
- Reset: all synchronisers, btn_db, btn_db_q, counters, held_code, evt_valid, evt_code and evt_overflow go to 0; repeat FSM goes to IDLE. Reset mid-debounce discards the partial count.

## Timing
- btn_in change sampled at edge 0 → sync2 at edge 1 → btn_db at edge 1+DEBOUNCE_CYCLES (if btn_in held stable) → evt_valid and held_code at edge 2+DEBOUNCE_CYCLES.
- A bounce (btn_in returns before the count completes) produces no btn_db change.
- Consumer accepts on the edge where evt_valid & evt_ready. Back-to-back events at one per cycle are allowed when evt_ready is held high.
- evt_valid does not depend combinationally on evt_ready.

## Configuration
- Macro BTN_AUTOREPEAT_EN.
  - Defined: repeat FSM with states IDLE, DELAY and REPEAT, plus a timer.
    - IDLE → DELAY when held_code ≠ 0 (timer cleared).
    - DELAY → REPEAT after REPEAT_DELAY cycles with held_code unchanged; a repeat event for held_code is issued on entry to REPEAT.
    - REPEAT issues a further event every REPEAT_PERIOD cycles.
    - Any held_code change returns to IDLE, or restarts DELAY if the new value is nonzero.
    - Repeat events use the same event register and overflow rules. An edge event in the same cycle wins; the repeat event is dropped silently, without setting overflow.
  - Undefined: no repeat logic or timer is synthesised, and events occur only on debounced rising edges.

## Test plan
Parameters: N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: rst low mid-activity → all outputs 0; evt_valid stays 0 for 5 cycles after release with btn_in=0.
- Clean press: btn_in=3'b010 held, evt_ready=1 → btn_db[1] rises at edge 5; evt_valid=1 with evt_code=2 for one cycle at edge 6; held_code=2 until release is debounced.
- Bounce: btn_in[0] pulses high for 3 cycles, then low → btn_db stays 0, no event.
- Simultaneous press: btn_in 3'b000→3'b101 in one cycle → evt_code=1, evt_overflow=1; ovf_clr pulse → evt_overflow=0.
- Backpressure: evt_ready=0, press btn 2, release, then press btn 0 → evt_code stays 3, evt_overflow=1; evt_ready=1 for one cycle → evt_valid=0.
- Auto-repeat (macro defined): hold btn_in=3'b001 with evt_ready=1 → edge event at cycle 6, repeat events at cycles 16, 19 and 22 (evt_code=1). Release → no further events. Same stimulus with the macro undefined → only the cycle-6 event.
